// File: rtl/seq_shifter.sv
// Multi-cycle logarithmic shifter: one barrel stage (1, 2, 4, 8 ...) per clock,
// with SLL/SRA/ROR/SRL modes and a start/busy/done handshake.
module seq_shifter #(
    parameter  int WIDTH = 16,
    localparam int SV_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [SV_W-1:0]  Shift_Val,
    input  logic [1:0]       Mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Shift_Out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } mode_e;

    localparam logic [SV_W-1:0] LAST_STAGE = SV_W'(SV_W - 1);

    state_e            state;
    state_e            state_next;
    logic [SV_W-1:0]   stage_cnt;
    logic [WIDTH-1:0]  work;
    logic [SV_W-1:0]   val_q;
    mode_e             mode_q;
    logic [WIDTH-1:0]  staged;
    logic [SV_W:0]     amt;
    logic [SV_W:0]     rot_amt;
    logic              last_stage;

    assign busy       = (state == SHIFT);
    assign last_stage = (stage_cnt == LAST_STAGE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = SHIFT;
            SHIFT:   if (last_stage) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage k shifts by 2^k when the captured amount has bit k set.
    always_comb begin
        amt     = (SV_W+1)'(1) << stage_cnt;
        rot_amt = (SV_W+1)'(WIDTH) - amt;
        staged  = work;
        if (val_q[stage_cnt]) begin
            case (mode_q)
                MODE_SLL: staged = work << amt;
                MODE_SRA: staged = $signed(work) >>> amt;
                MODE_ROR: staged = (work >> amt) | (work << rot_amt);
                MODE_SRL: staged = work >> amt;
                default:  staged = work;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_cnt <= '0;
            work      <= '0;
            val_q     <= '0;
            mode_q    <= MODE_SLL;
            Shift_Out <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    work      <= Shift_In;
                    val_q     <= Shift_Val;
                    mode_q    <= mode_e'(Mode);
                    stage_cnt <= '0;
                end
            end else begin
                work <= staged;
                if (last_stage) begin
                    // Counter is cleared rather than allowed to wrap.
                    stage_cnt <= '0;
                    Shift_Out <= staged;
                    done      <= 1'b1;
                end else begin
                    stage_cnt <= stage_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed testbench for seq_shifter: hand-computed vectors covering all modes,
// the start/done handshake, input changes in flight and asynchronous reset.
module tb_seq_shifter;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRL = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_Val;
    logic [1:0]  Mode;
    logic        busy;
    logic        done;
    logic [15:0] Shift_Out;

    int vec_count  = 0;
    int miss_count = 0;

    seq_shifter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Shift_In  (Shift_In),
        .Shift_Val (Shift_Val),
        .Mode      (Mode),
        .busy      (busy),
        .done      (done),
        .Shift_Out (Shift_Out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done, returning the number of edges taken.
    task automatic waitDone(input int start_cycles, output int cycles);
        cycles = start_cycles;
        while (!done && cycles < 12) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // One full operation; with scramble set the inputs change every cycle after acceptance.
    task automatic applyStimulus(input string tag, input logic [15:0] din, input logic [3:0] sv,
                                 input logic [1:0] md, input logic [15:0] expv, input bit scramble);
        int cycles;
        @(negedge clk);
        Shift_In  = din;
        Shift_Val = sv;
        Mode      = md;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, "/busy"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 12) begin
            if (scramble) begin
                Shift_In  = ~Shift_In ^ 16'h5A5A;
                Shift_Val = Shift_Val + 4'd5;
                Mode      = Mode + 2'd1;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, "/latency"}, cycles, 4);
        checkOutput({tag, "/done"}, done, 1);
        checkOutput({tag, "/busy_low"}, busy, 0);
        checkOutput({tag, "/result"}, Shift_Out, expv);
        @(posedge clk); #1;
        checkOutput({tag, "/done_pulse"}, done, 0);
        checkOutput({tag, "/hold"}, Shift_Out, expv);
    endtask

    initial begin
        int cycles;
        int done_seen;
        rst_n     = 1'b1;
        start     = 1'b0;
        Shift_In  = '0;
        Shift_Val = '0;
        Mode      = SLL;
        #2 rst_n = 1'b0;
        #6;
        checkOutput("reset/busy", busy, 0);
        checkOutput("reset/done", done, 0);
        checkOutput("reset/out", Shift_Out, 16'h0000);
        #4 rst_n = 1'b1;

        applyStimulus("sll15", 16'h0001, 4'd15, SLL, 16'h8000, 1'b0);
        applyStimulus("sll3",  16'h0001, 4'd3,  SLL, 16'h0008, 1'b0);
        applyStimulus("sra3",  16'h8000, 4'd3,  SRA, 16'hF000, 1'b0);
        applyStimulus("srl3",  16'h8000, 4'd3,  SRL, 16'h1000, 1'b0);
        applyStimulus("sra4p", 16'h7FF0, 4'd4,  SRA, 16'h07FF, 1'b0);
        applyStimulus("ror4",  16'h1234, 4'd4,  ROR, 16'h4123, 1'b0);
        applyStimulus("ror1",  16'h0001, 4'd1,  ROR, 16'h8000, 1'b0);
        applyStimulus("ror0",  16'hABCD, 4'd0,  ROR, 16'hABCD, 1'b0);
        applyStimulus("sll7",  16'h00FF, 4'd7,  SLL, 16'h7F80, 1'b0);
        applyStimulus("ror9",  16'h8001, 4'd9,  ROR, 16'h00C0, 1'b0);
        applyStimulus("scram", 16'h00F0, 4'd4,  SRL, 16'h000F, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        Shift_In = 16'h0001; Shift_Val = 4'd2; Mode = SLL; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        Shift_In = 16'hFFFF; Shift_Val = 4'd8; Mode = SRL; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("hs/busy_mid", busy, 1);
        checkOutput("hs/done_mid", done, 0);
        waitDone(1, cycles);
        checkOutput("hs/latency1", cycles, 4);
        checkOutput("hs/done1", done, 1);
        checkOutput("hs/result1", Shift_Out, 16'h0004);
        Shift_In = 16'hF000; Shift_Val = 4'd4; Mode = SRA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("hs/b2b_busy", busy, 1);
        checkOutput("hs/b2b_done", done, 0);
        checkOutput("hs/b2b_hold", Shift_Out, 16'h0004);
        waitDone(0, cycles);
        checkOutput("hs/latency2", cycles, 4);
        checkOutput("hs/done2", done, 1);
        checkOutput("hs/result2", Shift_Out, 16'hFF00);
        @(posedge clk); #1;
        checkOutput("hs/no_extra_done", done, 0);

        // Asynchronous reset in the middle of an operation.
        applyStimulus("pre_rst", 16'h0001, 4'd2, SLL, 16'h0004, 1'b0);
        @(negedge clk);
        Shift_In = 16'h00FF; Shift_Val = 4'd1; Mode = SLL; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst/busy", busy, 0);
        checkOutput("rst/done", done, 0);
        checkOutput("rst/out", Shift_Out, 16'h0000);
        #2 rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        checkOutput("rst/no_done", done_seen, 0);
        checkOutput("rst/out_held", Shift_Out, 16'h0000);
        applyStimulus("post_rst", 16'h8000, 4'd15, SRA, 16'hFFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
